lsu_access: RTL and testbench

- LSU stage body. It consumes the held EXU->LSU pipeline-register outputs through the lsu_valid / lsu_ready handshake.
- For loads and stores it runs one data-memory transaction on a simple req/rsp bus.
- It presents the result to the WBU with a valid / allow_in handshake.
- Non-memory instructions pass straight through with no added cycles.

---
 rtl/lsu_access.sv | 145 ++++++++++++++
 tb/tb_lsu_access.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_access.sv
// LSU stage body: issues one data-memory transaction per load/store and hands
// the result to the WBU; non-memory instructions pass straight through.
module lsu_access #(
   parameter int XLEN   = 64,
   parameter int INST_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   // EXU->LSU pipeline register handshake
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic              i_MemWr,
   input  logic [2:0]        i_MemOP,
   input  logic [INST_W-1:0] i_inst,
   input  logic [XLEN-1:0]   i_pc,
   input  logic [XLEN-1:0]   i_ALUres,
   input  logic [XLEN-1:0]   i_R_rs2,
   input  logic [1:0]        i_RegSrc,
   input  logic              i_RegWr,
   input  logic              i_IntrEn,
   input  logic [XLEN-1:0]   i_R_rs1,
   // data-memory request/response bus
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [XLEN-1:0]   mem_req_addr,
   output logic              mem_req_wen,
   output logic [XLEN-1:0]   mem_req_wdata,
   output logic [7:0]        mem_req_wmask,
   input  logic              mem_rsp_valid,
   input  logic [XLEN-1:0]   mem_rsp_rdata,
   // LSU->WBU handshake
   output logic              lsu_to_wbu_valid,
   input  logic              wbu_allow_in,
   output logic [INST_W-1:0] o_inst,
   output logic [XLEN-1:0]   o_pc,
   output logic [XLEN-1:0]   o_ALUres,
   output logic [1:0]        o_RegSrc,
   output logic              o_RegWr,
   output logic              o_IntrEn,
   output logic [XLEN-1:0]   o_R_rs1,
   output logic [XLEN-1:0]   o_MemRdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t          state_q, state_d;
   logic            mem_op;
   logic [2:0]      off;
   logic [7:0]      size_mask;
   logic [XLEN-1:0] raw;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] mem_rdata_q;

   assign mem_op = i_MemWr | (i_RegSrc == 2'b01);
   assign off    = i_ALUres[2:0];

   // Request fields come straight from the held pipeline register, so they
   // stay stable for as long as the request is stalled.
   assign mem_req_addr  = {i_ALUres[XLEN-1:3], 3'b000};
   assign mem_req_wen   = i_MemWr;
   assign mem_req_wdata = i_R_rs2 << {off, 3'b000};
   assign mem_req_wmask = size_mask << off;

   always_comb begin
      unique case (i_MemOP[1:0])
         2'b00:   size_mask = 8'h01;
         2'b01:   size_mask = 8'h03;
         2'b10:   size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   end

   // Bytes past lane 7 are simply shifted out; crossing accesses are unsupported.
   assign raw = mem_rsp_rdata >> {off, 3'b000};

   always_comb begin
      unique case (i_MemOP)
         3'b000:  load_data = {{(XLEN-8){raw[7]}}, raw[7:0]};
         3'b001:  load_data = {{(XLEN-16){raw[15]}}, raw[15:0]};
         3'b010:  load_data = {{(XLEN-32){raw[31]}}, raw[31:0]};
         3'b100:  load_data = {{(XLEN-8){1'b0}}, raw[7:0]};
         3'b101:  load_data = {{(XLEN-16){1'b0}}, raw[15:0]};
         3'b110:  load_data = {{(XLEN-32){1'b0}}, raw[31:0]};
         default: load_data = raw;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst)
         mem_rdata_q <= '0;
      else if (state_q == WAIT && mem_rsp_valid && !i_MemWr)
         mem_rdata_q <= load_data;
   end

   // NOTE: every output of this block is given a default first so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d          = state_q;
      mem_req_valid    = 1'b0;
      lsu_to_wbu_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (lsu_valid) begin
               if (mem_op) state_d = REQ;
               else        lsu_to_wbu_valid = 1'b1;
            end
         end
         REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_d = WAIT;
         end
         WAIT: begin
            if (mem_rsp_valid) state_d = DONE;
         end
         DONE: begin
            lsu_to_wbu_valid = 1'b1;
            if (wbu_allow_in) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (rst) begin
         mem_req_valid    = 1'b0;
         lsu_to_wbu_valid = 1'b0;
      end
   end

   assign lsu_ready = lsu_to_wbu_valid & wbu_allow_in;

   assign o_inst     = i_inst;
   assign o_pc       = i_pc;
   assign o_ALUres   = i_ALUres;
   assign o_RegSrc   = i_RegSrc;
   assign o_RegWr    = i_RegWr;
   assign o_IntrEn   = i_IntrEn;
   assign o_R_rs1    = i_R_rs1;
   assign o_MemRdata = mem_rdata_q;

endmodule

// File: tb/tb_lsu_access.sv
// Randomized bench for lsu_access: a transaction-level model predicts every
// cycle's handshake outputs, request fields and load data.
module tb_lsu_access;
   localparam int XLEN   = 64;
   localparam int INST_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              lsu_valid, lsu_ready;
   logic              i_MemWr;
   logic [2:0]        i_MemOP;
   logic [INST_W-1:0] i_inst;
   logic [XLEN-1:0]   i_pc, i_ALUres, i_R_rs2, i_R_rs1;
   logic [1:0]        i_RegSrc;
   logic              i_RegWr, i_IntrEn;
   logic              mem_req_valid, mem_req_ready, mem_req_wen;
   logic [XLEN-1:0]   mem_req_addr, mem_req_wdata;
   logic [7:0]        mem_req_wmask;
   logic              mem_rsp_valid;
   logic [XLEN-1:0]   mem_rsp_rdata;
   logic              lsu_to_wbu_valid, wbu_allow_in;
   logic [INST_W-1:0] o_inst;
   logic [XLEN-1:0]   o_pc, o_ALUres, o_R_rs1, o_MemRdata;
   logic [1:0]        o_RegSrc;
   logic              o_RegWr, o_IntrEn;

   lsu_access #(.XLEN(XLEN), .INST_W(INST_W)) dut (
      .clk(clk), .rst(rst),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
      .i_MemWr(i_MemWr), .i_MemOP(i_MemOP), .i_inst(i_inst), .i_pc(i_pc),
      .i_ALUres(i_ALUres), .i_R_rs2(i_R_rs2), .i_RegSrc(i_RegSrc),
      .i_RegWr(i_RegWr), .i_IntrEn(i_IntrEn), .i_R_rs1(i_R_rs1),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
      .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
      .lsu_to_wbu_valid(lsu_to_wbu_valid), .wbu_allow_in(wbu_allow_in),
      .o_inst(o_inst), .o_pc(o_pc), .o_ALUres(o_ALUres), .o_RegSrc(o_RegSrc),
      .o_RegWr(o_RegWr), .o_IntrEn(o_IntrEn), .o_R_rs1(o_R_rs1),
      .o_MemRdata(o_MemRdata)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [63:0] model_rdata;
   int          first_valid, done_cycle, n_hs;
   logic [63:0] obs_addr, obs_wdata, obs_rdata;
   logic [7:0]  obs_wmask;
   logic        obs_wen;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Byte-enable as the set of lanes [off, off+size) that fit in the doubleword.
   function automatic logic [7:0] mask_of(input logic [2:0] op, input logic [2:0] off);
      int n;
      logic [7:0] m;
      n = 1 << op[1:0];
      m = '0;
      for (int i = 0; i < 8; i++)
         if (i >= int'(off) && i < int'(off) + n) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [63:0] ext(input logic [63:0] w, input logic [2:0] op, input logic [2:0] off);
      logic [63:0] r;
      logic signed [63:0] s;
      r = w >> (8 * off);
      case (op)
         3'b000:  begin s = $signed(r[7:0]);  return s; end
         3'b001:  begin s = $signed(r[15:0]); return s; end
         3'b010:  begin s = $signed(r[31:0]); return s; end
         3'b100:  return {56'd0, r[7:0]};
         3'b101:  return {48'd0, r[15:0]};
         3'b110:  return {32'd0, r[31:0]};
         default: return r;
      endcase
   endfunction

   // One instruction from lsu_valid rising to lsu_ready, with a memory that
   // stalls ready by rdly cycles, answers sdly cycles after acceptance, and a
   // WBU that holds off allow_in for adly cycles once the result is valid.
   task automatic run_txn(input logic wr, input logic [1:0] regsrc, input logic [2:0] op,
                          input logic [63:0] addr, input logic [63:0] rs2, input logic [63:0] word,
                          input int rdly, input int sdly, input int adly);
      logic is_mem, hs, rd, done, exp_rv, exp_v, real_pulse;
      int stall, rcnt, acnt;
      logic [63:0] exp_addr, exp_wdata;
      logic [7:0]  exp_mask;
      is_mem = wr || (regsrc == 2'b01);
      hs = 0; rd = 0; done = 0; stall = 0; rcnt = 0; acnt = 0;
      exp_addr  = {addr[63:3], 3'b000};
      exp_wdata = rs2 << (8 * addr[2:0]);
      exp_mask  = mask_of(op, addr[2:0]);
      first_valid = -1; done_cycle = -1; n_hs = 0;
      @(negedge clk);
      lsu_valid = 1'b1; i_MemWr = wr; i_RegSrc = regsrc; i_MemOP = op;
      i_ALUres = addr; i_R_rs2 = rs2; i_inst = $urandom;
      i_pc = {$urandom, $urandom}; i_R_rs1 = {$urandom, $urandom};
      i_RegWr = 1'($urandom); i_IntrEn = 1'($urandom);
      for (int c = 0; c < 200 && !done; c++) begin
         if (c > 0) @(negedge clk);
         exp_rv = is_mem && c >= 1 && !hs;
         exp_v  = !is_mem || rd;
         mem_req_ready = exp_rv ? (stall >= rdly) : 1'($urandom);
         real_pulse    = is_mem && hs && !rd && rcnt == sdly;
         mem_rsp_valid = real_pulse || (!(hs && !rd) && $urandom_range(3) == 0);
         mem_rsp_rdata = real_pulse ? word : {$urandom, $urandom};
         wbu_allow_in  = exp_v ? (acnt >= adly) : 1'($urandom);
         #1;
         check("mem_req_valid", 64'(mem_req_valid), 64'(exp_rv));
         check("lsu_to_wbu_valid", 64'(lsu_to_wbu_valid), 64'(exp_v));
         check("lsu_ready", 64'(lsu_ready), 64'(exp_v && wbu_allow_in));
         check("o_MemRdata", o_MemRdata, model_rdata);
         check("passthru", {o_pc[31:0], o_inst}, {i_pc[31:0], i_inst});
         check("passthru2", {o_R_rs1[57:0], o_RegSrc, o_RegWr, o_IntrEn, o_ALUres[1:0]},
               {i_R_rs1[57:0], i_RegSrc, i_RegWr, i_IntrEn, i_ALUres[1:0]});
         if (exp_rv) begin
            check("req_addr", mem_req_addr, exp_addr);
            check("req_wen", 64'(mem_req_wen), 64'(wr));
            check("req_wmask", 64'(mem_req_wmask), 64'(exp_mask));
            if (wr) check("req_wdata", mem_req_wdata, exp_wdata);
         end
         if (lsu_to_wbu_valid && first_valid < 0) first_valid = c;
         if (mem_req_valid && mem_req_ready) begin
            n_hs++;
            obs_addr = mem_req_addr; obs_wdata = mem_req_wdata;
            obs_wmask = mem_req_wmask; obs_wen = mem_req_wen;
         end
         if (exp_rv) begin
            if (mem_req_ready) hs = 1'b1;
            else stall++;
         end else if (hs && !rd) begin
            if (real_pulse) begin
               rd = 1'b1;
               if (!wr) model_rdata = ext(word, op, addr[2:0]);
            end else rcnt++;
         end
         if (exp_v) begin
            if (wbu_allow_in) begin
               done = 1'b1; done_cycle = c; obs_rdata = o_MemRdata;
            end else acnt++;
         end
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL txn_timeout actual=no_lsu_ready expected=lsu_ready");
      end
      check("handshake_count", 64'(n_hs), 64'(is_mem));
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         lsu_valid     = 1'b0;
         mem_req_ready = 1'($urandom);
         mem_rsp_valid = ($urandom_range(3) == 0);
         mem_rsp_rdata = {$urandom, $urandom};
         wbu_allow_in  = 1'($urandom);
         #1;
         check("idle_req_valid", 64'(mem_req_valid), 64'd0);
         check("idle_wbu_valid", 64'(lsu_to_wbu_valid), 64'd0);
         check("idle_rdata", o_MemRdata, model_rdata);
      end
   endtask

   initial begin
      rst = 1'b1; lsu_valid = 1'b0; i_MemWr = 1'b0; i_MemOP = '0; i_inst = '0;
      i_pc = '0; i_ALUres = '0; i_R_rs2 = '0; i_RegSrc = '0; i_RegWr = 1'b0;
      i_IntrEn = 1'b0; i_R_rs1 = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0; wbu_allow_in = 1'b1;
      model_rdata = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_req_valid", 64'(mem_req_valid), 64'd0);
      check("rst_wbu_valid", 64'(lsu_to_wbu_valid), 64'd0);
      check("rst_lsu_ready", 64'(lsu_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_rdata", o_MemRdata, 64'd0);

      // ALU op passes through in the same cycle
      run_txn(1'b0, 2'b00, 3'b011, 64'h1234_5678, 64'd0, 64'd0, 0, 0, 0);
      check("alu_first_valid", 64'(first_valid), 64'd0);
      check("alu_no_req", 64'(n_hs), 64'd0);

      // lb at 0x8000_0005, zero-wait memory
      run_txn(1'b0, 2'b01, 3'b000, 64'h8000_0005, 64'd0, 64'h0000_8000_0000_0000, 0, 0, 0);
      check("lb_wmask", 64'(obs_wmask), 64'h20);
      check("lb_wen", 64'(obs_wen), 64'd0);
      check("lb_rdata", obs_rdata, 64'hFFFF_FFFF_FFFF_FF80);
      check("lb_latency", 64'(first_valid), 64'd3);

      // sh at 0x8000_0006
      run_txn(1'b1, 2'b00, 3'b001, 64'h8000_0006, 64'h1234, 64'hAAAA_5555_AAAA_5555, 0, 1, 0);
      check("sh_addr", obs_addr, 64'h8000_0000);
      check("sh_wen", 64'(obs_wen), 64'd1);
      check("sh_wmask", 64'(obs_wmask), 64'hC0);
      check("sh_wdata", obs_wdata, 64'h1234_0000_0000_0000);
      check("sh_rdata_kept", obs_rdata, 64'hFFFF_FFFF_FFFF_FF80);

      // lwu with stalled request and delayed response
      run_txn(1'b0, 2'b01, 3'b110, 64'h8000_0004, 64'd0, 64'hDEAD_BEEF_8765_4321, 4, 3, 0);
      check("lwu_rdata", obs_rdata, 64'h0000_0000_DEAD_BEEF);
      check("lwu_one_hs", 64'(n_hs), 64'd1);

      // lh with WBU back-pressure for 5 cycles
      run_txn(1'b0, 2'b01, 3'b001, 64'h8000_0002, 64'd0, 64'h0000_0000_8001_0000, 0, 0, 5);
      check("lh_rdata", obs_rdata, 64'hFFFF_FFFF_FFFF_8001);
      check("lh_first_valid", 64'(first_valid), 64'd3);
      check("lh_held_cycles", 64'(done_cycle - first_valid), 64'd5);

      // reset while waiting for a response; the late pulse must be ignored
      @(negedge clk);
      lsu_valid = 1'b1; i_MemWr = 1'b0; i_RegSrc = 2'b01; i_MemOP = 3'b011;
      i_ALUres = 64'h8000_0010; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      wbu_allow_in = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b1;
      #1;
      check("rstw_req_valid", 64'(mem_req_valid), 64'd1);
      @(negedge clk);
      mem_req_ready = 1'b0; rst = 1'b1;
      #1;
      check("rstw_in_rst_req", 64'(mem_req_valid), 64'd0);
      check("rstw_in_rst_wbu", 64'(lsu_to_wbu_valid), 64'd0);
      @(negedge clk);
      rst = 1'b0; lsu_valid = 1'b0; mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 64'hFEED_FACE_CAFE_BEEF;
      model_rdata = '0;
      #1;
      check("rstw_rdata_cleared", o_MemRdata, 64'd0);
      check("rstw_wbu_valid", 64'(lsu_to_wbu_valid), 64'd0);
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      #1;
      check("rstw_pulse_ignored", o_MemRdata, 64'd0);
      check("rstw_wbu_valid2", 64'(lsu_to_wbu_valid), 64'd0);
      check("rstw_req_valid2", 64'(mem_req_valid), 64'd0);

      // random mix of ALU, CSR, load and store instructions
      for (int t = 0; t < 300; t++) begin
         int kind;
         logic wr;
         logic [1:0] rs;
         kind = $urandom_range(3);
         wr = (kind == 2);
         rs = (kind == 0) ? (1'($urandom) ? 2'b10 : 2'b00) :
              (kind == 2) ? 2'b00 : 2'b01;
         run_txn(wr, rs, 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, $urandom_range(3), $urandom_range(3), $urandom_range(3));
         if ($urandom_range(2) == 0) idle_cycles($urandom_range(1, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
